// File: rtl/k_countdown_if.sv
// Handshake-free bus bundle for the k_countdown lane bank.
// master drives controls and presets; slave returns counts and borrows.
interface k_countdown_if #(
  parameter int WIDTH = 3,
  parameter int LANES = 3
);
  logic [LANES-1:0]       kc_en;
  logic [LANES-1:0]       pla;
  logic [LANES-1:0]       load;
  logic [LANES*WIDTH-1:0] preset;
  logic [LANES*WIDTH-1:0] k;
  logic [LANES-1:0]       zero;
  logic [LANES-1:0]       busy;
  logic                   k0;

  modport master (
    output kc_en, pla, load, preset,
    input  k, zero, busy, k0
  );

  modport slave (
    input  kc_en, pla, load, preset,
    output k, zero, busy, k0
  );
endinterface

// File: rtl/k_countdown.sv
// Three-lane preset down-counter bank with per-lane borrow pulse.
// Optional AUTO_RELOAD_EN: terminal tick reloads the captured preset.
module k_countdown #(
  parameter int WIDTH = 3,
  parameter int LANES = 3
) (
  input logic        clk,
  input logic        rst_n,
  k_countdown_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  logic [LANES*WIDTH-1:0] k_w;
  logic [LANES-1:0]       zero_w;
  logic [LANES-1:0]       busy_w;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] pset;
    state_t           st;
    logic             z;
    logic             b;
`ifdef AUTO_RELOAD_EN
    logic [WIDTH-1:0] cap;
`endif

    assign pset = bus.preset[i*WIDTH +: WIDTH];

    // Priority per edge: deselect, then load, then decrement.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st  <= IDLE;
        cnt <= '0;
        z   <= 1'b0;
        b   <= 1'b0;
`ifdef AUTO_RELOAD_EN
        cap <= '0;
`endif
      end else begin
        z <= 1'b0;
        if (!bus.pla[i]) begin
          st  <= IDLE;
          cnt <= '0;
          b   <= 1'b0;
        end else if (bus.load[i]) begin
          cnt <= pset;
`ifdef AUTO_RELOAD_EN
          cap <= pset;
`endif
          if (pset != '0) begin
            st <= RUN;
            b  <= 1'b1;
          end else begin
            st <= DONE;
            b  <= 1'b0;
            z  <= 1'b1;
          end
        end else if (st == RUN && bus.kc_en[i]) begin
          if (cnt == WIDTH'(1)) begin
            z <= 1'b1;
`ifdef AUTO_RELOAD_EN
            cnt <= cap;
`else
            cnt <= '0;
            st  <= DONE;
            b   <= 1'b0;
`endif
          end else begin
            cnt <= cnt - WIDTH'(1);
          end
        end
      end
    end

    assign k_w[i*WIDTH +: WIDTH] = cnt;
    assign zero_w[i]             = z;
    assign busy_w[i]             = b;
  end

  assign bus.k    = k_w;
  assign bus.zero = zero_w;
  assign bus.busy = busy_w;
  assign bus.k0   = |zero_w;

endmodule

// File: tb/tb_k_countdown.sv
// Bench for k_countdown: directed table, async reset and
// randomized traffic against a behavioural lane model.
module tb_k_countdown;

  localparam int W = 3;
  localparam int L = 3;

  logic clk;
  logic rst_n;

  k_countdown_if #(.WIDTH(W), .LANES(L)) bus ();

  k_countdown #(.WIDTH(W), .LANES(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [2:0] en;
    logic [2:0] pla;
    logic [2:0] ld;
    logic [8:0] pre;
    logic [8:0] ek;
    logic [2:0] ez;
    logic [2:0] eb;
    logic       ek0;
  } vec_t;

  vec_t vecs[$];

  // Reference model: remaining count, running flag, captured preset.
  int         mk[L];
  int         mpre[L];
  bit         mrun[L];
  logic [2:0] mz;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] en, input logic [2:0] pla,
                       input logic [2:0] ld, input logic [8:0] pre);
    bus.kc_en  = en;
    bus.pla    = pla;
    bus.load   = ld;
    bus.preset = pre;
  endtask

  function automatic void add(input logic [2:0] en, input logic [2:0] pla,
                              input logic [2:0] ld, input logic [8:0] pre,
                              input logic [8:0] ek, input logic [2:0] ez,
                              input logic [2:0] eb);
    vec_t v;
    v.en = en; v.pla = pla; v.ld = ld; v.pre = pre;
    v.ek = ek; v.ez = ez; v.eb = eb; v.ek0 = (ez != 3'b000);
    vecs.push_back(v);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < L; i++) begin
      mk[i] = 0; mpre[i] = 0; mrun[i] = 0;
    end
    mz = '0;
  endfunction

  function automatic void model_step(input logic [2:0] en,
                                     input logic [2:0] pla,
                                     input logic [2:0] ld,
                                     input logic [8:0] pre);
    for (int i = 0; i < L; i++) begin
      int p;
      p = int'((pre >> (i * W)) & 9'h7);
      mz[i] = 1'b0;
      if (!pla[i]) begin
        mk[i] = 0; mrun[i] = 0;
      end else if (ld[i]) begin
        mk[i] = p; mpre[i] = p;
        mrun[i] = (p != 0);
        mz[i] = (p == 0);
      end else if (mrun[i] && en[i]) begin
        if (mk[i] == 1) begin
          mz[i] = 1'b1;
`ifdef AUTO_RELOAD_EN
          mk[i] = mpre[i];
`else
          mk[i] = 0; mrun[i] = 0;
`endif
        end else begin
          mk[i] = mk[i] - 1;
        end
      end
    end
  endfunction

  function automatic logic [8:0] model_k();
    logic [8:0] r;
    r = '0;
    for (int i = 0; i < L; i++) r = r | (9'(mk[i]) << (i * W));
    return r;
  endfunction

  function automatic logic [2:0] model_b();
    logic [2:0] r;
    for (int i = 0; i < L; i++) r[i] = mrun[i];
    return r;
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, ".k"},    32'(bus.k),    32'(model_k()));
    chk({tag, ".zero"}, 32'(bus.zero), 32'(mz));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(model_b()));
    chk({tag, ".k0"},   32'(bus.k0),   32'(mz != 3'b000));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(3'b000, 3'b000, 3'b000, 9'h000);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.k", 32'(bus.k), 32'h0);
    chk("rst.zero", 32'(bus.zero), 32'h0);
    chk("rst.busy", 32'(bus.busy), 32'h0);
    chk("rst.k0", 32'(bus.k0), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset lands between edges.
    drive(3'b000, 3'b111, 3'b001, 9'h005);
    @(posedge clk); #1;
    chk("arst.pre.k", 32'(bus.k), 32'h5);
    chk("arst.pre.busy", 32'(bus.busy), 32'h1);
    drive(3'b001, 3'b111, 3'b000, 9'h000);
    rst_n = 1'b0;
    #1;
    chk("arst.k", 32'(bus.k), 32'h0);
    chk("arst.busy", 32'(bus.busy), 32'h0);
    chk("arst.zero", 32'(bus.zero), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b000, 3'b111, 3'b000, 9'h000);
    @(posedge clk); #1;
    chk("arst.idle.k", 32'(bus.k), 32'h0);

`ifndef AUTO_RELOAD_EN
    // lane0 countdown 3,2,1,0
    add(3'b000, 3'b111, 3'b001, 9'h003, 9'h003, 3'b000, 3'b001);
    add(3'b001, 3'b111, 3'b000, 9'h000, 9'h002, 3'b000, 3'b001);
    add(3'b001, 3'b111, 3'b000, 9'h000, 9'h001, 3'b000, 3'b001);
    add(3'b001, 3'b111, 3'b000, 9'h000, 9'h000, 3'b001, 3'b000);
    add(3'b001, 3'b111, 3'b000, 9'h000, 9'h000, 3'b000, 3'b000);
    // lane1 preset 6, hold four cycles, then count
    add(3'b000, 3'b111, 3'b010, 9'h030, 9'h030, 3'b000, 3'b010);
    for (int j = 0; j < 4; j++)
      add(3'b000, 3'b111, 3'b000, 9'h000, 9'h030, 3'b000, 3'b010);
    add(3'b010, 3'b111, 3'b000, 9'h000, 9'h028, 3'b000, 3'b010);
    add(3'b010, 3'b111, 3'b000, 9'h000, 9'h020, 3'b000, 3'b010);
    // lane2 k=4, then deselect with load asserted
    add(3'b000, 3'b111, 3'b100, 9'h100, 9'h120, 3'b000, 3'b110);
    add(3'b000, 3'b011, 3'b100, 9'h1C0, 9'h020, 3'b000, 3'b010);
    // lane0 at 1: load beats terminal tick
    add(3'b000, 3'b111, 3'b001, 9'h001, 9'h021, 3'b000, 3'b011);
    add(3'b001, 3'b111, 3'b001, 9'h005, 9'h025, 3'b000, 3'b011);
    // lanes 0 and 1 borrow together
    add(3'b000, 3'b111, 3'b011, 9'h012, 9'h012, 3'b000, 3'b011);
    add(3'b011, 3'b111, 3'b000, 9'h000, 9'h009, 3'b000, 3'b011);
    add(3'b011, 3'b111, 3'b000, 9'h000, 9'h000, 3'b011, 3'b000);
    add(3'b011, 3'b111, 3'b000, 9'h000, 9'h000, 3'b000, 3'b000);
    // all lanes loaded with zero
    add(3'b000, 3'b111, 3'b111, 9'h000, 9'h000, 3'b111, 3'b000);
    add(3'b111, 3'b111, 3'b000, 9'h000, 9'h000, 3'b000, 3'b000);

    foreach (vecs[n]) begin
      drive(vecs[n].en, vecs[n].pla, vecs[n].ld, vecs[n].pre);
      @(posedge clk); #1;
      chk($sformatf("vec%0d.k", n), 32'(bus.k), 32'(vecs[n].ek));
      chk($sformatf("vec%0d.zero", n), 32'(bus.zero), 32'(vecs[n].ez));
      chk($sformatf("vec%0d.busy", n), 32'(bus.busy), 32'(vecs[n].eb));
      chk($sformatf("vec%0d.k0", n), 32'(bus.k0), 32'(vecs[n].ek0));
    end
`else
    // Modulo-2 divider on lane0.
    drive(3'b000, 3'b111, 3'b001, 9'h002);
    @(posedge clk); #1;
    chk("ar.load.k", 32'(bus.k), 32'h2);
    for (int j = 0; j < 6; j++) begin
      drive(3'b001, 3'b111, 3'b000, 9'h000);
      @(posedge clk); #1;
      chk($sformatf("ar%0d.k", j), 32'(bus.k), (j % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("ar%0d.zero", j), 32'(bus.zero),
          (j % 2 == 0) ? 32'h0 : 32'h1);
      chk($sformatf("ar%0d.busy", j), 32'(bus.busy), 32'h1);
    end
`endif

    // Randomized traffic against the model, from a clean reset.
    @(negedge clk);
    drive(3'b000, 3'b000, 3'b000, 9'h000);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic [2:0] en, pla, ld;
      logic [8:0] pre;
      for (int i = 0; i < L; i++) begin
        pla[i] = ($urandom_range(0, 15) != 0);
        ld[i]  = ($urandom_range(0, 5) == 0);
        en[i]  = ($urandom_range(0, 9) < 6);
      end
      pre = 9'($urandom);
      drive(en, pla, ld, pre);
      @(posedge clk);
      model_step(en, pla, ld, pre);
      #1;
      chk_model($sformatf("rnd%0d", c));
      if (c == 1500) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_model("rnd.arst");
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
